decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction-decode / operand-fetch pipeline stage of the MIPS core; sits directly upstream of the register file.
//  Drives the register-file read addresses from the incoming instruction and bypasses same-cycle write-back data.
//  Captures operands, immediate, destination and control into a valid/ready ID/EX register.
//  Inserts a one-cycle bubble on load-use hazards and supports a pipeline flush.
// PARAMETERS
//  LW_OPCODE   6'h23   opcode treated as a load for load-use interlock
//  CNT_W       16      width of the saturating stall counter
// PORTS
//  Clk         in   1   clock; all state updates on rising edge
//  Rst_n       in   1   asynchronous, active-low reset
//  Instr_in    in   32  instruction word from fetch
//  Instr_valid in   1   Instr_in valid
//  Instr_ready out  1   stage accepts Instr_in this cycle
//  Ard1        out  5   register-file read address 1 = Instr_in[25:21] (rs)
//  Ard2        out  5   register-file read address 2 = Instr_in[20:16] (rt)
//  Dout1       in   32  register-file read data 1 (combinational)
//  Dout2       in   32  register-file read data 2 (combinational)
//  Wb_WrEn     in   1   write-back write enable (same signal as register-file WrEn)
//  Wb_Awr      in   5   write-back address (same as register-file Awr)
//  Wb_Din      in   32  write-back data (same as register-file Din)
//  Flush       in   1   discard the ID/EX entry and block capture this cycle
//  Ex_ready    in   1   execute stage accepts the ID/EX entry
//  Ex_valid    out  1   ID/EX entry valid
//  Ex_A        out  32  rs operand
//  Ex_B        out  32  rt operand
//  Ex_Imm      out  32  extended immediate
//  Ex_Rd       out  5   destination register
//  Ex_Opcode   out  6   Instr[31:26]
//  Ex_Func     out  6   Instr[5:0]
//  Ex_RegWr    out  1   entry writes the register file
//  Stall_cnt   out  CNT_W  number of load-use bubble cycles, saturating
// BEHAVIOUR
//  - Reset (Rst_n=0, async): all Ex_* outputs = 0, Ex_valid = 0, Stall_cnt = 0.
//  - Ard1/Ard2 are combinational from Instr_in and are independent of Instr_valid.
//  - Bypass: opA = (Wb_WrEn && Wb_Awr==Ard1 && Ard1!=0) ? Wb_Din : Dout1; opB likewise with Ard2.
//    The register file updates on the edge, so a same-cycle write must come from the bypass.
//  - hazard = Ex_valid & (Ex_Opcode==LW_OPCODE) & Ex_Rd!=0 & (Ex_Rd==Ard1 | Ex_Rd==Ard2).
//  - Instr_ready = (~Ex_valid | Ex_ready) & ~hazard & ~Flush.
//  - Capture (Instr_valid & Instr_ready): Ex_valid<=1 and all Ex_* fields are loaded from decode of Instr_in.
//  - No capture and (Ex_ready | Flush): Ex_valid<=0, the data fields hold. A hazard with Ex_ready set gives a 1-cycle bubble.
//  - Hold (Ex_valid & ~Ex_ready & ~Flush): fields are frozen, except when Wb_WrEn and Wb_Awr equals the held rs/rt (nonzero).
//    In that case Ex_A/Ex_B reload from Wb_Din (hold-update).
//  - Latency: 1 cycle from accepted instruction to Ex_valid.
//  - Decode rules:
//    - Ex_Rd = Instr[15:11] if opcode==0, else Instr[20:16].
//    - Ex_Imm is zero-extended for opcodes 0x0C/0x0D/0x0E, sign-extended otherwise.
//    - Ex_RegWr = 0 for opcodes 0x2B, 0x04, 0x05, 0x02 or when Ex_Rd==0; otherwise 1.
//  - Stall_cnt increments on each cycle with Instr_valid & hazard; it saturates at all-ones.
//  - Flush has priority over capture and hazard, and Stall_cnt does not count during Flush.
//  - Reset asserted mid-operation clears the entry immediately; Stall_cnt restarts at 0.
// TESTING
//  1. Reset with Rst_n=0 and random inputs -> Ex_valid=0, Ex_A=0, Stall_cnt=0; after release Instr_ready=1.
//  2. Instr 0x012A4020 (add $8,$9,$10), Dout1=5, Dout2=7, Ex_ready=1 -> next cycle: Ex_valid=1, Ex_A=5, Ex_B=7, Ex_Rd=8, Ex_RegWr=1.
//  3. Same instr with Wb_WrEn=1, Wb_Awr=9, Wb_Din=0xDEAD -> Ex_A=0xDEAD. Repeat with Wb_Awr=0 -> Ex_A=Dout1.
//  4. Issue lw $8,4($0), then add $9,$8,$8 -> 1 bubble cycle (Instr_ready=0, Ex_valid=0 after lw is consumed), add is accepted next, Stall_cnt=1.
//  5. Ex_ready=0 holding ori $3,$4,0xFFFF (Ex_Imm=0x0000FFFF); Wb write $4=0x11 -> Ex_A=0x11; Flush=1 -> Ex_valid=0 next cycle.
//  6. addi $2,$0,-1 -> Ex_Imm=0xFFFFFFFF; sw -> Ex_RegWr=0; addi $0,... -> Ex_RegWr=0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode / operand-fetch stage: drives register-file reads, bypasses write-back,
// and holds the decoded instruction in a valid/ready ID/EX register with load-use interlock.
module decode_stage #(
  parameter logic [5:0] LW_OPCODE = 6'h23,
  parameter int         CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      Instr_in,
  input  logic             Instr_valid,
  output logic             Instr_ready,
  output logic [4:0]       Ard1,
  output logic [4:0]       Ard2,
  input  logic [31:0]      Dout1,
  input  logic [31:0]      Dout2,
  input  logic             Wb_WrEn,
  input  logic [4:0]       Wb_Awr,
  input  logic [31:0]      Wb_Din,
  input  logic             Flush,
  input  logic             Ex_ready,
  output logic             Ex_valid,
  output logic [31:0]      Ex_A,
  output logic [31:0]      Ex_B,
  output logic [31:0]      Ex_Imm,
  output logic [4:0]       Ex_Rd,
  output logic [5:0]       Ex_Opcode,
  output logic [5:0]       Ex_Func,
  output logic             Ex_RegWr,
  output logic [CNT_W-1:0] Stall_cnt
);

  function automatic logic [4:0] dec_rd(input logic [31:0] instr);
    return (instr[31:26] == 6'h00) ? instr[15:11] : instr[20:16];
  endfunction

  function automatic logic [31:0] dec_imm(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
      return {16'h0000, instr[15:0]};
    return {{16{instr[15]}}, instr[15:0]};
  endfunction

  function automatic logic dec_regwr(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02)
      return 1'b0;
    return (dec_rd(instr) != 5'd0);
  endfunction

  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_a_q, ex_a_d;
  logic [31:0]      ex_b_q, ex_b_d;
  logic [31:0]      ex_imm_q, ex_imm_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [4:0]       ex_rs_q, ex_rs_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic [5:0]       ex_opcode_q, ex_opcode_d;
  logic [5:0]       ex_func_q, ex_func_d;
  logic             ex_regwr_q, ex_regwr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] op_a, op_b;
  logic        hazard, ready, capture;

  assign Ard1 = Instr_in[25:21];
  assign Ard2 = Instr_in[20:16];

  // The register file writes on the edge, so a same-cycle write-back must be forwarded here.
  assign op_a = (Wb_WrEn && Wb_Awr == Ard1 && Ard1 != 5'd0) ? Wb_Din : Dout1;
  assign op_b = (Wb_WrEn && Wb_Awr == Ard2 && Ard2 != 5'd0) ? Wb_Din : Dout2;

  assign hazard  = ex_valid_q && (ex_opcode_q == LW_OPCODE) && (ex_rd_q != 5'd0) &&
                   ((ex_rd_q == Ard1) || (ex_rd_q == Ard2));
  assign ready   = (!ex_valid_q || Ex_ready) && !hazard && !Flush;
  assign capture = Instr_valid && ready;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_imm_d    = ex_imm_q;
    ex_rd_d     = ex_rd_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_opcode_d = ex_opcode_q;
    ex_func_d   = ex_func_q;
    ex_regwr_d  = ex_regwr_q;
    stall_cnt_d = stall_cnt_q;

    if (capture) begin
      ex_valid_d  = 1'b1;
      ex_a_d      = op_a;
      ex_b_d      = op_b;
      ex_imm_d    = dec_imm(Instr_in);
      ex_rd_d     = dec_rd(Instr_in);
      ex_rs_d     = Ard1;
      ex_rt_d     = Ard2;
      ex_opcode_d = Instr_in[31:26];
      ex_func_d   = Instr_in[5:0];
      ex_regwr_d  = dec_regwr(Instr_in);
    end else if (Ex_ready || Flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_valid_q) begin
      // A held entry must not miss a write-back to one of its source registers.
      if (Wb_WrEn && Wb_Awr == ex_rs_q && ex_rs_q != 5'd0) ex_a_d = Wb_Din;
      if (Wb_WrEn && Wb_Awr == ex_rt_q && ex_rt_q != 5'd0) ex_b_d = Wb_Din;
    end

    if (Instr_valid && hazard && !Flush && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_rd_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_opcode_q <= '0;
      ex_func_q   <= '0;
      ex_regwr_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_opcode_q <= ex_opcode_d;
      ex_func_q   <= ex_func_d;
      ex_regwr_q  <= ex_regwr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Instr_ready = ready;
  assign Ex_valid    = ex_valid_q;
  assign Ex_A        = ex_a_q;
  assign Ex_B        = ex_b_q;
  assign Ex_Imm      = ex_imm_q;
  assign Ex_Rd       = ex_rd_q;
  assign Ex_Opcode   = ex_opcode_q;
  assign Ex_Func     = ex_func_q;
  assign Ex_RegWr    = ex_regwr_q;
  assign Stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, bypass, load-use bubble, hold-update, flush, saturation.
module tb_decode_stage;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic [31:0]      Instr_in;
  logic             Instr_valid;
  logic             Instr_ready;
  logic [4:0]       Ard1, Ard2;
  logic [31:0]      Dout1, Dout2;
  logic             Wb_WrEn;
  logic [4:0]       Wb_Awr;
  logic [31:0]      Wb_Din;
  logic             Flush;
  logic             Ex_ready;
  logic             Ex_valid;
  logic [31:0]      Ex_A, Ex_B, Ex_Imm;
  logic [4:0]       Ex_Rd;
  logic [5:0]       Ex_Opcode, Ex_Func;
  logic             Ex_RegWr;
  logic [CNT_W-1:0] Stall_cnt;

  int total = 0;
  int bad   = 0;

  decode_stage #(.LW_OPCODE(6'h23), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr_in(Instr_in), .Instr_valid(Instr_valid),
    .Instr_ready(Instr_ready), .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
    .Wb_WrEn(Wb_WrEn), .Wb_Awr(Wb_Awr), .Wb_Din(Wb_Din), .Flush(Flush), .Ex_ready(Ex_ready),
    .Ex_valid(Ex_valid), .Ex_A(Ex_A), .Ex_B(Ex_B), .Ex_Imm(Ex_Imm), .Ex_Rd(Ex_Rd),
    .Ex_Opcode(Ex_Opcode), .Ex_Func(Ex_Func), .Ex_RegWr(Ex_RegWr), .Stall_cnt(Stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n       = 1'b0;
    Instr_in    = $urandom;
    Instr_valid = 1'($urandom);
    Dout1       = $urandom;
    Dout2       = $urandom;
    Wb_WrEn     = 1'($urandom);
    Wb_Awr      = 5'($urandom);
    Wb_Din      = $urandom;
    Flush       = 1'($urandom);
    Ex_ready    = 1'($urandom);
    #23;
    chk("rst_valid", Ex_valid, 0);
    chk("rst_a", Ex_A, 0);
    chk("rst_imm", Ex_Imm, 0);
    chk("rst_cnt", Stall_cnt, 0);

    @(posedge Clk); #1;
    Instr_valid = 1'b0; Flush = 1'b0; Ex_ready = 1'b1; Wb_WrEn = 1'b0;
    Rst_n = 1'b1;
    #1;
    chk("rst_ready", Instr_ready, 1);

    // add $8,$9,$10
    Instr_in = 32'h012A4020; Instr_valid = 1'b1; Dout1 = 32'd5; Dout2 = 32'd7;
    #1;
    chk("ard1", Ard1, 9);
    chk("ard2", Ard2, 10);
    step();
    chk("add_valid", Ex_valid, 1);
    chk("add_a", Ex_A, 5);
    chk("add_b", Ex_B, 7);
    chk("add_rd", Ex_Rd, 8);
    chk("add_regwr", Ex_RegWr, 1);
    chk("add_func", Ex_Func, 32'h20);
    chk("add_imm", Ex_Imm, 32'h00004020);

    Wb_WrEn = 1'b1; Wb_Awr = 5'd9; Wb_Din = 32'hDEAD;
    step();
    chk("byp_a", Ex_A, 32'hDEAD);
    chk("byp_a_b", Ex_B, 7);
    Wb_Awr = 5'd10;
    step();
    chk("byp_b_a", Ex_A, 5);
    chk("byp_b", Ex_B, 32'hDEAD);
    // add $8,$0,$10 with write to $0: never bypassed
    Instr_in = 32'h000A4020; Wb_Awr = 5'd0;
    step();
    chk("byp_r0", Ex_A, 5);
    chk("byp_r0_b", Ex_B, 7);

    // lw $8,4($0) then add $9,$8,$8
    Wb_WrEn = 1'b0; Instr_in = 32'h8C080004;
    step();
    chk("lw_valid", Ex_valid, 1);
    chk("lw_op", Ex_Opcode, 32'h23);
    chk("lw_rd", Ex_Rd, 8);
    chk("lw_imm", Ex_Imm, 4);
    Instr_in = 32'h01084820;
    #1;
    chk("haz_ready", Instr_ready, 0);
    step();
    chk("bub_valid", Ex_valid, 0);
    chk("bub_cnt", Stall_cnt, 1);
    chk("bub_ready", Instr_ready, 1);
    step();
    chk("use_valid", Ex_valid, 1);
    chk("use_rd", Ex_Rd, 9);
    chk("use_cnt", Stall_cnt, 1);

    // ori $3,$4,0xFFFF held by Ex_ready=0
    Instr_in = 32'h3483FFFF; Dout1 = 32'h44; Dout2 = 32'h33;
    step();
    Ex_ready = 1'b0; Instr_in = 32'h012A4020;
    #1;
    chk("hold_ready", Instr_ready, 0);
    chk("ori_imm", Ex_Imm, 32'h0000FFFF);
    chk("ori_rd", Ex_Rd, 3);
    chk("ori_a", Ex_A, 32'h44);
    Wb_WrEn = 1'b1; Wb_Awr = 5'd4; Wb_Din = 32'h11;
    step();
    chk("hupd_a", Ex_A, 32'h11);
    chk("hupd_b", Ex_B, 32'h33);
    chk("hupd_valid", Ex_valid, 1);
    chk("hupd_imm", Ex_Imm, 32'h0000FFFF);
    Wb_WrEn = 1'b0; Flush = 1'b1;
    step();
    chk("flush_valid", Ex_valid, 0);
    Flush = 1'b0;

    // Flush during a load-use hazard must not count
    Ex_ready = 1'b1; Instr_in = 32'h8C080004;
    step();
    Ex_ready = 1'b0; Instr_in = 32'h01084820;
    step();
    chk("hcnt_hold", Stall_cnt, 2);
    Flush = 1'b1;
    step();
    chk("flush_nocnt", Stall_cnt, 2);
    chk("flush_hvalid", Ex_valid, 0);
    Flush = 1'b0;

    // Saturation with a held load
    Ex_ready = 1'b1; Instr_in = 32'h8C080004;
    step();
    Ex_ready = 1'b0; Instr_in = 32'h01084820;
    repeat (20) step();
    chk("sat_cnt", Stall_cnt, 15);
    Ex_ready = 1'b1;
    step();
    chk("sat_bub", Ex_valid, 0);
    chk("sat_hold", Stall_cnt, 15);

    // addi $2,$0,-1
    Instr_in = 32'h2002FFFF;
    step();
    chk("addi_imm", Ex_Imm, 32'hFFFFFFFF);
    chk("addi_rd", Ex_Rd, 2);
    chk("addi_regwr", Ex_RegWr, 1);
    // sw $5,8($6)
    Instr_in = 32'hACC50008;
    step();
    chk("sw_regwr", Ex_RegWr, 0);
    chk("sw_rd", Ex_Rd, 5);
    // addi $0,$1,5
    Instr_in = 32'h20200005;
    step();
    chk("r0_regwr", Ex_RegWr, 0);
    chk("r0_rd", Ex_Rd, 0);
    chk("r0_valid", Ex_valid, 1);

    // Asynchronous reset mid-operation
    Instr_valid = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("mrst_valid", Ex_valid, 0);
    chk("mrst_imm", Ex_Imm, 0);
    chk("mrst_cnt", Stall_cnt, 0);
    step();
    Rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
